// File: rtl/booth_pkg.sv
// Shared types and helpers for the booth multiplier datapath and its consumers.
package booth_pkg;

   localparam int unsigned PROD_W_DEFAULT = 8;
   localparam int unsigned SEXT_W         = 64;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   // Sign-extend the low w bits of p to SEXT_W bits; callers truncate to their width.
   function automatic logic [SEXT_W-1:0] sext_prod(input logic [SEXT_W-1:0] p,
                                                   input int unsigned       w);
      logic [SEXT_W-1:0] mask;
      logic [SEXT_W-1:0] sh;
      mask = (SEXT_W'(1) << w) - SEXT_W'(1);
      sh   = p >> (w - 1);
      return sh[0] ? (p | ~mask) : (p & mask);
   endfunction

endpackage

// File: rtl/booth_done_edge.sv
// Rising-edge detector on the multiplier's level done; a held level yields one take.
module booth_done_edge (
   input  logic clk,
   input  logic reset,
   input  logic prod_done,
   output logic take_c
);

   logic done_q;

   // Resets high so a done already asserted at reset release is not counted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) done_q <= 1'b1;
      else        done_q <= prod_done;
   end

   assign take_c = prod_done & ~done_q;

endmodule

// File: rtl/booth_dot_accumulator.sv
// Sums NUM_TERMS signed multiplier products into one dot-product result and
// offers it on a valid/ready handshake.
module booth_dot_accumulator
   import booth_pkg::*;
#(
   parameter int unsigned PROD_W    = PROD_W_DEFAULT,
   parameter int unsigned ACC_W     = 16,
   parameter int unsigned NUM_TERMS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_done,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [7:0]        term_cnt,
   output logic              overflow,
   output logic              drop_err
);

   localparam logic [7:0] LAST_TERM = 8'(NUM_TERMS - 1);

   acc_state_t       state;
   logic             take_c;
   logic [ACC_W-1:0] prod_ext_c;
   logic [ACC_W-1:0] sum_c;
   logic             ovf_c;

   booth_done_edge u_done_edge (
      .clk       (clk),
      .reset     (reset),
      .prod_done (prod_done),
      .take_c    (take_c)
   );

   assign prod_ext_c = ACC_W'(sext_prod(SEXT_W'(prod_in), PROD_W));
   assign sum_c      = acc_out + prod_ext_c;
   // Signed wrap: operands agree in sign but the sum does not.
   assign ovf_c      = (acc_out[ACC_W-1] == prod_ext_c[ACC_W-1]) &&
                       (sum_c[ACC_W-1] != acc_out[ACC_W-1]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ACCUM;
         acc_out   <= '0;
         acc_valid <= 1'b0;
         term_cnt  <= '0;
         overflow  <= 1'b0;
         drop_err  <= 1'b0;
      end else if (clear) begin
         state     <= ACCUM;
         acc_out   <= '0;
         acc_valid <= 1'b0;
         term_cnt  <= '0;
         overflow  <= 1'b0;
         drop_err  <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (take_c) begin
                  acc_out  <= sum_c;
                  term_cnt <= term_cnt + 8'd1;
                  if (ovf_c) overflow <= 1'b1;
                  if (term_cnt == LAST_TERM) begin
                     acc_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (acc_valid && acc_ready) begin
                  acc_valid <= 1'b0;
                  overflow  <= 1'b0;
                  state     <= ACCUM;
                  // A product landing on the transfer cycle opens the next sum.
                  if (take_c) begin
                     acc_out  <= prod_ext_c;
                     term_cnt <= 8'd1;
                  end else begin
                     acc_out  <= '0;
                     term_cnt <= '0;
                  end
               end else if (take_c) begin
                  drop_err <= 1'b1;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Randomized and directed bench for booth_dot_accumulator against a sum-of-products model.
module tb_booth_dot_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        prod_done;
   logic [7:0]  prod_in;
   logic        acc_ready;

   logic [15:0] acc_out;
   logic        acc_valid;
   logic [7:0]  term_cnt;
   logic        overflow;
   logic        drop_err;

   logic [7:0]  acc_out_s;
   logic        acc_valid_s;
   logic [7:0]  term_cnt_s;
   logic        overflow_s;
   logic        drop_err_s;

   int checks = 0;
   int errors = 0;
   logic [15:0] xfer_q[$];

   booth_dot_accumulator #(.PROD_W(8), .ACC_W(16), .NUM_TERMS(4)) dut (
      .clk(clk), .reset(reset), .clear(clear), .prod_in(prod_in), .prod_done(prod_done),
      .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .term_cnt(term_cnt), .overflow(overflow), .drop_err(drop_err)
   );

   // Narrow accumulator instance to exercise signed wrap.
   booth_dot_accumulator #(.PROD_W(8), .ACC_W(8), .NUM_TERMS(2)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .prod_in(prod_in), .prod_done(prod_done),
      .acc_out(acc_out_s), .acc_valid(acc_valid_s), .acc_ready(acc_ready),
      .term_cnt(term_cnt_s), .overflow(overflow_s), .drop_err(drop_err_s)
   );

   always #5 clk = ~clk;

   // Record every result that the next rising edge will transfer.
   always @(negedge clk) begin
      if (reset && !clear && acc_valid && acc_ready) xfer_q.push_back(acc_out);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_product(input logic [7:0] p, input int hold, input int gap);
      prod_in   = p;
      prod_done = 1'b1;
      tick(hold);
      prod_done = 1'b0;
      tick(gap);
   endtask

   function automatic int wrap(input int v, input int w);
      int m;
      int r;
      m = 1 << w;
      r = v % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  p;
      logic [15:0] e16;
      logic [7:0]  e8;
      int          sum;
      int          a8;
      int          s8;
      logic        ovf8;
      int          wait_cnt;

      reset = 1'b0; clear = 1'b0; prod_done = 1'b1; prod_in = 8'h00; acc_ready = 1'b0;
      tick(3);
      check("rst_acc_out",   32'(acc_out),   32'd0);
      check("rst_acc_valid", 32'(acc_valid), 32'd0);
      check("rst_term_cnt",  32'(term_cnt),  32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_drop_err",  32'(drop_err),  32'd0);
      check("rst_s_acc_out", 32'(acc_out_s), 32'd0);

      // Done held high across reset release must not count.
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("held_done_cnt",   32'(term_cnt),  32'd0);
         check("held_done_valid", 32'(acc_valid), 32'd0);
      end
      prod_done = 1'b0;
      tick(2);

      // Products 6, -6, 15, -8 -> 7.
      apply_product(8'd6,  5, 1);
      apply_product(8'hFA, 5, 1);
      apply_product(8'd15, 5, 1);
      check("seq_partial_cnt", 32'(term_cnt), 32'd3);
      check("seq_partial_acc", 32'(acc_out),  32'd15);
      prod_in = 8'hF8; prod_done = 1'b1;
      check("seq_valid_before", 32'(acc_valid), 32'd0);
      tick(1);
      check("seq_valid_after", 32'(acc_valid), 32'd1);
      check("seq_acc_out",     32'(acc_out),   32'h0007);
      check("seq_term_cnt",    32'(term_cnt),  32'd4);
      tick(4);
      prod_done = 1'b0;

      // Back-pressure: result stays put, then exactly one transfer.
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("bp_acc_out", 32'(acc_out),   32'h0007);
         check("bp_valid",   32'(acc_valid), 32'd1);
      end
      xfer_q.delete();
      acc_ready = 1'b1;
      tick(1);
      acc_ready = 1'b0;
      tick(3);
      check("bp_xfer_count", 32'(xfer_q.size()), 32'd1);
      if (xfer_q.size() > 0) check("bp_xfer_value", 32'(xfer_q[0]), 32'h0007);
      check("bp_post_cnt",   32'(term_cnt),  32'd0);
      check("bp_post_valid", 32'(acc_valid), 32'd0);

      // Take coincident with the handshake starts the next sum.
      sum = 0;
      for (int k = 0; k < 4; k++) begin
         p = 8'($urandom);
         sum += int'($signed(p));
         apply_product(p, int'($urandom_range(3, 1)), int'($urandom_range(2, 1)));
      end
      e16 = 16'(sum);
      check("hold_valid", 32'(acc_valid), 32'd1);
      check("hold_acc",   32'(acc_out),   32'(e16));
      xfer_q.delete();
      prod_in = 8'd9; prod_done = 1'b1; acc_ready = 1'b1;
      tick(1);
      acc_ready = 1'b0;
      check("coinc_xfer_count", 32'(xfer_q.size()), 32'd1);
      if (xfer_q.size() > 0) check("coinc_xfer_value", 32'(xfer_q[0]), 32'(e16));
      check("coinc_acc",   32'(acc_out),   32'd9);
      check("coinc_cnt",   32'(term_cnt),  32'd1);
      check("coinc_drop",  32'(drop_err),  32'd0);
      check("coinc_valid", 32'(acc_valid), 32'd0);
      tick(2);
      prod_done = 1'b0;
      tick(1);

      // Finish that sum, then drop a product while stalled.
      sum = 9;
      for (int k = 0; k < 3; k++) begin
         p = 8'($urandom);
         sum += int'($signed(p));
         apply_product(p, int'($urandom_range(3, 1)), 1);
      end
      e16 = 16'(sum);
      check("drop_pre_acc", 32'(acc_out), 32'(e16));
      prod_in = 8'($urandom); prod_done = 1'b1;
      tick(1);
      check("drop_err_set", 32'(drop_err),  32'd1);
      check("drop_acc",     32'(acc_out),   32'(e16));
      check("drop_cnt",     32'(term_cnt),  32'd4);
      check("drop_valid",   32'(acc_valid), 32'd1);
      prod_done = 1'b0;
      tick(1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("clr_acc",   32'(acc_out),   32'd0);
      check("clr_cnt",   32'(term_cnt),  32'd0);
      check("clr_valid", 32'(acc_valid), 32'd0);
      check("clr_ovf",   32'(overflow),  32'd0);
      check("clr_drop",  32'(drop_err),  32'd0);

      // Alternating extremes sum exactly with no overflow.
      apply_product(8'h80, 1, 1);
      apply_product(8'h7F, 2, 1);
      apply_product(8'h80, 1, 2);
      apply_product(8'h7F, 1, 1);
      check("ext_acc", 32'(acc_out),  32'hFFFE);
      check("ext_ovf", 32'(overflow), 32'd0);
      acc_ready = 1'b1;
      tick(1);
      acc_ready = 1'b0;

      // Random rounds; acc_ready toggles freely while nothing is valid.
      for (int r = 0; r < 30; r++) begin
         xfer_q.delete();
         sum = 0;
         for (int k = 0; k < 4; k++) begin
            p = 8'($urandom);
            sum += int'($signed(p));
            acc_ready = 1'($urandom_range(1, 0));
            apply_product(p, int'($urandom_range(3, 1)), int'($urandom_range(3, 1)));
            if (k < 3) begin
               e16 = 16'(sum);
               check("rnd_partial_cnt", 32'(term_cnt), 32'(k + 1));
               check("rnd_partial_acc", 32'(acc_out),  32'(e16));
            end
         end
         acc_ready = 1'b1;
         wait_cnt = 0;
         while (xfer_q.size() == 0 && wait_cnt < 20) begin
            tick(1);
            wait_cnt++;
         end
         acc_ready = 1'b0;
         tick(1);
         e16 = 16'(sum);
         check("rnd_xfer_count", 32'(xfer_q.size()), 32'd1);
         if (xfer_q.size() > 0) check("rnd_xfer_value", 32'(xfer_q[0]), 32'(e16));
         check("rnd_post_cnt",  32'(term_cnt), 32'd0);
         check("rnd_post_ovf",  32'(overflow), 32'd0);
         check("rnd_post_drop", 32'(drop_err), 32'd0);
      end

      // Async reset in the middle of a sum.
      apply_product(8'd33, 2, 1);
      apply_product(8'd44, 2, 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_acc", 32'(acc_out),  32'd0);
      check("async_rst_cnt", 32'(term_cnt), 32'd0);
      tick(1);
      reset = 1'b1;
      tick(2);

      // Narrow accumulator: 127 + 127 wraps to 0xFE.
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      apply_product(8'd127, 2, 1);
      apply_product(8'd127, 2, 1);
      check("wrap_acc",   32'(acc_out_s),   32'h00FE);
      check("wrap_ovf",   32'(overflow_s),  32'd1);
      check("wrap_valid", 32'(acc_valid_s), 32'd1);
      acc_ready = 1'b1;
      tick(1);
      acc_ready = 1'b0;
      check("wrap_post_ovf",   32'(overflow_s),  32'd0);
      check("wrap_post_valid", 32'(acc_valid_s), 32'd0);

      // Random narrow sums against an exact-integer model of wrap and overflow.
      for (int r = 0; r < 12; r++) begin
         a8 = 0;
         ovf8 = 1'b0;
         for (int k = 0; k < 2; k++) begin
            p = 8'($urandom);
            s8 = a8 + int'($signed(p));
            if (s8 > 127 || s8 < -128) ovf8 = 1'b1;
            a8 = wrap(s8, 8);
            apply_product(p, int'($urandom_range(2, 1)), 1);
         end
         e8 = 8'(a8);
         check("nrw_acc",   32'(acc_out_s),   32'(e8));
         check("nrw_ovf",   32'(overflow_s),  32'(ovf8));
         check("nrw_valid", 32'(acc_valid_s), 32'd1);
         acc_ready = 1'b1;
         tick(1);
         acc_ready = 1'b0;
         check("nrw_post_ovf", 32'(overflow_s), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
